ahb_master_req_ctrl: RTL

AHB_MASTER_REQ_CTRL -- requirements
Module: ahb_master_req_ctrl

---
 rtl/ahb_master_req_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ahb_master_req_ctrl.sv
// AHB master-side request controller: decodes the slave index and raises a one-hot request to
// that slave's arbiter. It counts beats until the burst completes and flags decode errors.
module ahb_master_req_ctrl #(
  parameter int unsigned SLAVE_NUM  = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hburst,
  input  logic [SLAVE_NUM-1:0]  hgrant,
  output logic [SLAVE_NUM-1:0]  hreq,
  output logic                  hready,
  output logic                  herror,
  output logic                  busy
);

  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransNonseq = 2'd2;
  localparam logic [2:0] BurstSingle = 3'd0;
  localparam logic [2:0] BurstIncr   = 3'd1;

  typedef enum logic [2:0] {StIdle, StReq, StXfer, StErr1, StErr2} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic                   incr_q, incr_d;
  logic [4:0]             limit_q, limit_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [SLAVE_NUM-1:0]   hreq_q, hreq_d;

  logic [3:0]  idx;
  logic        idx_ok;
  logic [15:0] grant_pad;
  logic        beat;
  logic        last;
  logic [4:0]  burst_limit;
  logic        unused_addr;

  assign idx         = haddr[ADDR_WIDTH-1 -: 4];
  assign idx_ok      = {1'b0, idx} < 5'(SLAVE_NUM);
  assign grant_pad   = 16'(hgrant);
  assign unused_addr = ^haddr[ADDR_WIDTH-5:0];

  // Only the grant from the captured slave matters; BUSY (htrans[1]=0) never counts.
  assign beat = ((state_q == StReq) || (state_q == StXfer)) && grant_pad[idx_q] && htrans[1];
  assign last = (beat && !incr_q && (cnt_q == limit_q - 5'd1)) ||
                ((state_q == StXfer) && incr_q && (htrans == TransIdle));

  always_comb begin
    burst_limit = 5'd0;
    unique case (hburst)
      BurstSingle:  burst_limit = 5'd1;
      BurstIncr:    burst_limit = 5'd0;
      3'd2, 3'd3:   burst_limit = 5'd4;
      3'd4, 3'd5:   burst_limit = 5'd8;
      default:      burst_limit = 5'd16;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      incr_q  <= 1'b0;
      limit_q <= '0;
      cnt_q   <= '0;
      hreq_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      incr_q  <= incr_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      hreq_q  <= hreq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    incr_d  = incr_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    hreq_d  = hreq_q;
    unique case (state_q)
      StIdle: begin
        if (htrans == TransNonseq) begin
          cnt_d = '0;
          if (idx_ok) begin
            state_d = StReq;
            idx_d   = idx;
            incr_d  = (hburst == BurstIncr);
            limit_d = burst_limit;
            for (int i = 0; i < SLAVE_NUM; i++) begin
              hreq_d[i] = (idx == 4'(i));
            end
          end else begin
            state_d = StErr1;
          end
        end
      end
      StReq, StXfer: begin
        // Saturate rather than wrap on very long INCR bursts.
        if (beat && (cnt_q != 5'd31)) cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d = StIdle;
          hreq_d  = '0;
        end else if (beat) begin
          state_d = StXfer;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hready = ((state_q == StIdle) && (htrans != TransNonseq)) || beat || (state_q == StErr2);
    herror = (state_q == StErr1) || (state_q == StErr2);
    busy   = (state_q != StIdle);
  end

  assign hreq = hreq_q;

endmodule
